// File: rtl/filt_pkg.sv
// filt_pkg: shared filter-mode encodings, sizing constants and mode-scheduler states.
package filt_pkg;
    localparam int NUM_MODES = 7;
    localparam int MODE_W    = 3;

    typedef enum logic [2:0] {
        MODE_BYPASS        = 3'd0,
        MODE_GAMMA14       = 3'd1,
        MODE_GAMMA22       = 3'd2,
        MODE_BRIGHT        = 3'd3,
        MODE_YUV_BRIGHT    = 3'd4,
        MODE_YUV_GAMMA14   = 3'd5,
        MODE_YUV_ROUNDTRIP = 3'd6
    } mode_e;

    typedef enum logic {IDLE, ARMED} state_e;
endpackage

// File: rtl/filter_mode_sched_btn_debounce.sv
// btn_debounce: two-flop synchroniser and counter debounce for an assert-low button,
// with a one-cycle strobe on each debounced press (stable 1->0).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2, level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/filter_mode_sched.sv
// filter_mode_sched: accumulates debounced button presses into a pending mode and
// commits it to the filter datapath only on a vsync rising edge.
module filter_mode_sched #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_MODES       = filt_pkg::NUM_MODES,
    parameter int MODE_W          = filt_pkg::MODE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_n,
    input  logic              vsync,
    output logic [MODE_W-1:0] mode,
    output logic              pending,
    output logic              mode_changed
);
    import filt_pkg::*;

    state_e            state, state_n;
    logic [MODE_W-1:0] next_mode, next_mode_n, mode_n;
    logic              changed_n, press, vs1, vs2, vs3, vs_rise;

    function automatic logic [MODE_W-1:0] adv(input logic [MODE_W-1:0] m);
        return (m == MODE_W'(NUM_MODES - 1)) ? '0 : m + 1'b1;
    endfunction

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_n),
        .press (press)
    );

    assign vs_rise = vs2 & ~vs3;
    assign pending = (state == ARMED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {vs1, vs2, vs3} <= 3'b000;
            state           <= IDLE;
            mode            <= '0;
            next_mode       <= '0;
            mode_changed    <= 1'b0;
        end else begin
            {vs1, vs2, vs3} <= {vsync, vs1, vs2};
            state           <= state_n;
            mode            <= mode_n;
            next_mode       <= next_mode_n;
            mode_changed    <= changed_n;
        end
    end

    // A press in the commit cycle advances from the value being committed.
    always_comb begin
        state_n     = state;
        mode_n      = mode;
        next_mode_n = next_mode;
        changed_n   = 1'b0;
        if (state == ARMED && vs_rise) begin
            mode_n    = next_mode;
            changed_n = 1'b1;
            state_n   = IDLE;
        end
        if (press) begin
            next_mode_n = adv(state == ARMED ? next_mode : mode);
            state_n     = ARMED;
        end
    end
endmodule

// File: doc/filter_mode_sched.md
Name: filter_mode_sched

Overview:
- Sequences the mode select of the colour-filter datapath (gamma/brightness/YUV stages) from a raw assert-low push button.
- Debounces the button and accumulates mode-advance requests.
- Commits the new mode only on a frame boundary (vsync rising edge), so a frame is never rendered with two filter modes.
- Sits between board I/O and the filter datapath's mode input; replaces driving the mode register directly from the button.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive synchronised samples differing from stable level before stable level flips (min 2).
- NUM_MODES, 7, number of filter modes; mode index wraps NUM_MODES-1 -> 0.
- MODE_W, 3, width of mode index; must satisfy 2**MODE_W >= NUM_MODES.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset  in  1  asynchronous, active-high reset.
- btn_n  in  1  raw mode-advance button, assert-low, asynchronous to clk, bouncy.
- vsync  in  1  frame sync, active-high, asynchronous; rising edge = frame boundary.
- mode  out  MODE_W  committed filter mode driven to datapath.
- pending  out  1  high while an uncommitted mode request exists.
- mode_changed  out  1  one-cycle pulse on the cycle mode updates.

Behaviour:
- Interface fixed: single clock clk; reset asynchronous, active-high; all state cleared immediately on reset assertion, independent of clk.
- Reset values:
  - mode=0, pending=0, mode_changed=0, next_mode=0.
  - btn stable level=1 (released), debounce counter=0.
  - btn sync flops=1, vsync sync/delay flops=0.
- Synchronisers: two flops each on btn_n and vsync; only second-stage outputs used.
- Debounce:
  - counter increments while synced btn differs from stable level; clears to 0 on any cycle they match.
  - on reaching DEBOUNCE_CYCLES, stable level takes synced value and counter clears.
  - Raw edge -> stable flip = 2 + DEBOUNCE_CYCLES clocks.
- Press event: one-cycle strobe on stable 1->0 transition only; release generates nothing.
- vsync edge: vs_rise = synced vsync & ~delayed vsync. mode updates on the 3rd clk edge after raw vsync rises.
- FSM, two states:
  - IDLE: pending=0.
    - press -> next_mode = (mode==NUM_MODES-1 ? 0 : mode+1), go ARMED.
    - vs_rise ignored.
  - ARMED: pending=1.
    - press -> next_mode advances by one with wrap.
    - vs_rise and no press -> mode<=next_mode, mode_changed=1 for one cycle, go IDLE.
- Simultaneous press and vs_rise in ARMED: commit the pre-press next_mode, pulse mode_changed, then advance next_mode for the new press; stay ARMED (pending stays 1).
- Simultaneous press and vs_rise in IDLE: press registers, go ARMED; no commit this frame.
- Multiple presses in one frame accumulate with wrap. If next_mode wraps back to the current mode, commit still occurs and mode_changed still pulses.
- Button held indefinitely: exactly one press. vsync held high: exactly one vs_rise.
- Reset mid-ARMED: pending request discarded; mode returns to 0 (bypass).
- No combinational path from inputs to outputs; all outputs registered.

Decomposition:
- Shared package filt_pkg:
  - mode encodings: MODE_BYPASS=0, MODE_GAMMA14=1, MODE_GAMMA22=2, MODE_BRIGHT=3, MODE_YUV_BRIGHT=4, MODE_YUV_GAMMA14=5, MODE_YUV_ROUNDTRIP=6.
  - NUM_MODES and MODE_W constants.
  - FSM state typedef {IDLE, ARMED}.
- One sub-module: btn_debounce (2-flop sync + counter + stable level + falling-edge strobe), parameterised by DEBOUNCE_CYCLES; reusable for other board buttons.
- vsync sync/edge detect and FSM stay in the top.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then one clean btn_n low pulse of 10 cycles, then vsync rise -> pending=1 from press strobe until commit; mode 0->1 on 3rd clk after vsync rise; mode_changed high exactly 1 cycle.
- btn_n bounces (low 2, high 1, low 2, high 1) then low 8 cycles -> exactly one press; after vsync, mode=1 not 2+.
- Three clean presses within one frame from mode 5 -> next_mode 6,0,1; after vsync mode=1, pending=0.
- Press strobe coincident with vs_rise while ARMED with next_mode=2 (mode=1) -> mode=2 committed, pending stays 1, next vsync commits mode=3.
- Seven presses from mode 4 then vsync -> mode stays 4, mode_changed still pulses once.
- Assert reset asynchronously mid-cycle while ARMED at mode=3 -> mode=0, pending=0, mode_changed=0 immediately; next vsync with no press leaves mode=0.
